// File: rtl/rle_pkg.sv
// Token format shared by the RLE compressor and decompressor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rle_pkg;

  // Default run-count field width; token = {value bit, run length - 1}.
  localparam int CNT_W_DEF = 2;
  localparam int TOKEN_W   = CNT_W_DEF + 1;
  localparam int MAX_CNT   = (1 << CNT_W_DEF) - 1;

  // Field positions inside a token.
  localparam int VAL_POS = TOKEN_W - 1;
  localparam int CNT_MSB = CNT_W_DEF - 1;

  typedef logic [TOKEN_W-1:0] token_t;

endpackage

// File: rtl/rle_token_fifo.sv
// Generic synchronous FIFO holding encoded tokens.
// Latency: a word pushed at edge k is visible at rdata after edge k.
// Backpressure: full/empty are registered-count based; push-while-full is legal only with a pop in the same cycle.
module rle_token_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/rle_compressor.sv
// Serial run-length encoder: raw bits in, {value, count} tokens buffered, re-serialised MSB first.
// Latency: token pushed at edge k drives serOut after k+1 when the shifter is empty; one bit per clock sustained.
// Backpressure: stackFull blocks input while the token FIFO is full; outReady=0 freezes serOut/bitValid.
module rle_compressor
  import rle_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic sclk,
  input  logic rst,
  input  logic serIn,
  input  logic inValid,
  input  logic flush,
  output logic stackFull,
  output logic serOut,
  output logic bitValid,
  input  logic outReady,
  output logic idle
);

  localparam int TOK_W = CNT_W + 1;
  localparam int LW    = $clog2(CNT_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Open run state
  logic             run_active;
  logic             run_bit;
  logic [CNT_W-1:0] run_cnt;

  // Token FIFO interface
  logic             fifo_push;
  logic             fifo_pop;
  logic [TOK_W-1:0] fifo_wdata;
  logic [TOK_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  // Serializer state: bits of the current token not yet on serOut
  logic [CNT_W-1:0] sh_rest;
  logic [LW-1:0]    bits_left;

  logic accept;
  logic run_break;
  logic flush_go;
  logic advance;
  logic last_bit;

  assign stackFull = fifo_full;
  assign accept    = inValid & ~stackFull;
  // A run closes on a value change or when its count field is saturated.
  assign run_break = run_active & ((serIn != run_bit) | (run_cnt == CNT_MAX));
  // Flush only wins on cycles with no incoming bit, so bit order is never ambiguous.
  assign flush_go  = ~inValid & flush & run_active & ~fifo_full;

  assign fifo_push  = (accept & run_break) | flush_go;
  assign fifo_wdata = {run_bit, run_cnt};

  assign advance  = bitValid & outReady;
  assign last_bit = advance & (bits_left == '0);
  // Reloading on the final consumed bit keeps consecutive tokens bubble-free.
  assign fifo_pop = ~fifo_empty & (~bitValid | last_bit);

  assign idle = ~run_active & fifo_empty & ~bitValid;

  rle_token_fifo #(
    .WIDTH (TOK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (sclk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Run tracker: extend, restart or close the open run
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      run_active <= 1'b0;
      run_bit    <= 1'b0;
      run_cnt    <= '0;
    end else if (accept) begin
      if (!run_active || run_break) begin
        run_active <= 1'b1;
        run_bit    <= serIn;
        run_cnt    <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end else if (flush_go) begin
      run_active <= 1'b0;
      run_cnt    <= '0;
    end
  end

  // Serializer: load a token from the FIFO head, then shift one bit per consumed beat
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      bitValid  <= 1'b0;
      serOut    <= 1'b0;
      sh_rest   <= '0;
      bits_left <= '0;
    end else if (fifo_pop) begin
      bitValid  <= 1'b1;
      serOut    <= fifo_head[TOK_W-1];
      sh_rest   <= fifo_head[CNT_W-1:0];
      bits_left <= LW'(CNT_W);
    end else if (advance) begin
      if (bits_left == '0) begin
        bitValid <= 1'b0;
        serOut   <= 1'b0;
      end else begin
        serOut    <= sh_rest[CNT_W-1];
        sh_rest   <= sh_rest << 1;
        bits_left <= bits_left - 1'b1;
      end
    end
  end

endmodule
